// File: rtl/porta_and_struct.sv
// -----------------------------------------------------------------------------
// porta_and_struct
//
// Purpose:
//   Bit-wise 2-input AND cell over a WIDTH-bit vector, built from one gate
//   primitive per bit. The combinational result y has zero latency. Around it
//   sit a registered copy of the result and a small activity monitor. With the
//   default WIDTH=1 this is a plain AND gate.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous, active-high reset
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B
//   y         out  WIDTH  combinational a AND b, bit-wise (valid during reset)
//   y_q       out  WIDTH  y sampled on clk
//   all_high  out  1      combinational reduction-AND of y
//   rise      out  1      registered one-cycle pulse on an all_high 0->1 edge
//   high_cnt  out  CNT_W  saturating count of cycles with all_high=1
// -----------------------------------------------------------------------------
module porta_and_struct #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             all_high,
    output logic             rise,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] VEC_ZERO = {WIDTH{1'b0}};

    // Saturating increment: advance only when enabled and not yet at the top,
    // so the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             en
    );
        logic [CNT_W-1:0] res;
        if (en && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Gate-level result, one primitive per bit.
    wire [WIDTH-1:0] y_s;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            and u_and (y_s[gi], a[gi], b[gi]);
        end
    endgenerate

    logic             all_high_s;
    logic [WIDTH-1:0] y_q_q;
    logic [WIDTH-1:0] y_q_d;
    logic             prev_all_q;
    logic             prev_all_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;

    // Reduction over the gate outputs; for WIDTH=1 this is simply y.
    assign all_high_s = &y_s;

    // Next-state for the register copy and the activity monitor.
    always_comb begin
        y_q_d      = y_s;
        prev_all_d = all_high_s;
        // prev_all resets to 0, so all_high already high on the first edge
        // after reset still counts as a rising transition.
        rise_d     = all_high_s & ~prev_all_q;
        high_cnt_d = sat_inc(high_cnt_q, all_high_s);
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_q      <= VEC_ZERO;
            prev_all_q <= 1'b0;
            rise_q     <= 1'b0;
            high_cnt_q <= CNT_ZERO;
        end else begin
            y_q_q      <= y_q_d;
            prev_all_q <= prev_all_d;
            rise_q     <= rise_d;
            high_cnt_q <= high_cnt_d;
        end
    end

    assign y        = y_s;
    assign all_high = all_high_s;
    assign y_q      = y_q_q;
    assign rise     = rise_q;
    assign high_cnt = high_cnt_q;

endmodule

// File: tb/tb_porta_and_struct.sv
module tb_porta_and_struct;

    logic       clk;
    logic       rst;

    // WIDTH=1, CNT_W=8 instance
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] y1;
    logic [0:0] yq1;
    logic       ah1;
    logic       rise1;
    logic [7:0] cnt1;

    // WIDTH=4, CNT_W=2 instance (vector and saturation cases)
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] y4;
    logic [3:0] yq4;
    logic       ah4;
    logic       rise4;
    logic [1:0] cnt4;

    int n_cmp;
    int n_err;

    porta_and_struct #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1),
        .all_high(ah1), .rise(rise1), .high_cnt(cnt1)
    );

    porta_and_struct #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(yq4),
        .all_high(ah4), .rise(rise4), .high_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y4;
        logic       ah4;
        logic       y1;   // WIDTH=1 instance sees bit 0 only
    } comb_vec_t;

    comb_vec_t cv[7];

    // Multi-cycle sequence: dut1 input per edge, dut4 held at all-ones.
    logic       seq_a1   [6];
    logic       seq_rise1[6];
    logic [7:0] seq_cnt1 [6];
    logic [1:0] seq_cnt4 [6];
    logic       seq_rise4[6];

    initial begin
        n_cmp = 0;
        n_err = 0;

        cv[0] = '{a: 4'b0000, b: 4'b0000, y4: 4'b0000, ah4: 1'b0, y1: 1'b0};
        cv[1] = '{a: 4'b0000, b: 4'b0001, y4: 4'b0000, ah4: 1'b0, y1: 1'b0};
        cv[2] = '{a: 4'b0001, b: 4'b0000, y4: 4'b0000, ah4: 1'b0, y1: 1'b0};
        cv[3] = '{a: 4'b0001, b: 4'b0001, y4: 4'b0001, ah4: 1'b0, y1: 1'b1};
        cv[4] = '{a: 4'b1100, b: 4'b1010, y4: 4'b1000, ah4: 1'b0, y1: 1'b0};
        cv[5] = '{a: 4'b1111, b: 4'b1111, y4: 4'b1111, ah4: 1'b1, y1: 1'b1};
        cv[6] = '{a: 4'b0101, b: 4'b1111, y4: 4'b0101, ah4: 1'b0, y1: 1'b1};

        seq_a1[0] = 1'b1; seq_a1[1] = 1'b0; seq_a1[2] = 1'b1;
        seq_a1[3] = 1'b1; seq_a1[4] = 1'b0; seq_a1[5] = 1'b0;
        seq_rise1[0] = 1'b1; seq_rise1[1] = 1'b0; seq_rise1[2] = 1'b1;
        seq_rise1[3] = 1'b0; seq_rise1[4] = 1'b0; seq_rise1[5] = 1'b0;
        seq_cnt1[0] = 8'd1; seq_cnt1[1] = 8'd1; seq_cnt1[2] = 8'd2;
        seq_cnt1[3] = 8'd3; seq_cnt1[4] = 8'd3; seq_cnt1[5] = 8'd3;
        seq_cnt4[0] = 2'd1; seq_cnt4[1] = 2'd2; seq_cnt4[2] = 2'd3;
        seq_cnt4[3] = 2'd3; seq_cnt4[4] = 2'd3; seq_cnt4[5] = 2'd3;
        seq_rise4[0] = 1'b1; seq_rise4[1] = 1'b0; seq_rise4[2] = 1'b0;
        seq_rise4[3] = 1'b0; seq_rise4[4] = 1'b0; seq_rise4[5] = 1'b0;

        // Reset state
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        #1;
        chk("rst_yq1", yq1, 1'b0);
        chk("rst_rise1", rise1, 1'b0);
        chk("rst_cnt1", cnt1, 8'd0);
        chk("rst_yq4", yq4, 4'h0);
        chk("rst_cnt4", cnt4, 2'd0);

        // Combinational table, applied while reset is held (y must still work)
        for (int i = 0; i < 7; i++) begin
            a4 = cv[i].a;  b4 = cv[i].b;
            a1 = cv[i].a[0]; b1 = cv[i].b[0];
            #1;
            chk($sformatf("comb_y4[%0d]", i), y4, cv[i].y4);
            chk($sformatf("comb_ah4[%0d]", i), ah4, cv[i].ah4);
            chk($sformatf("comb_y1[%0d]", i), y1, cv[i].y1);
            chk($sformatf("comb_ah1[%0d]", i), ah1, cv[i].y1);
            #9;
        end

        // Register path on dut1
        a4 = 4'h0; b4 = 4'h0;
        @(negedge clk);
        rst = 1'b0; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        chk("reg_yq1", yq1, 1'b1);
        chk("reg_rise1_first", rise1, 1'b1);
        chk("reg_cnt1_first", cnt1, 8'd1);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("reg_rise1_hold%0d", k), rise1, 1'b0);
            chk($sformatf("reg_cnt1_hold%0d", k), cnt1, k);
        end

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_yq1", yq1, 1'b0);
        chk("arst_rise1", rise1, 1'b0);
        chk("arst_cnt1", cnt1, 8'd0);
        chk("arst_y1", y1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_restart_cnt1", cnt1, 8'd1);
        chk("arst_restart_rise1", rise1, 1'b1);

        // Drop/re-rise on dut1, saturation and vector rise on dut4
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a4 = 4'hF; b4 = 4'hF;
        a1 = seq_a1[0]; b1 = 1'b1;
        #1;
        chk("vec_y4_all", y4, 4'hF);
        chk("vec_ah4_all", ah4, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("seq_rise1[%0d]", k), rise1, seq_rise1[k]);
            chk($sformatf("seq_cnt1[%0d]", k), cnt1, seq_cnt1[k]);
            chk($sformatf("seq_yq1[%0d]", k), yq1, seq_a1[k]);
            chk($sformatf("sat_cnt4[%0d]", k), cnt4, seq_cnt4[k]);
            chk($sformatf("sat_rise4[%0d]", k), rise4, seq_rise4[k]);
            chk($sformatf("sat_yq4[%0d]", k), yq4, 4'hF);
            @(negedge clk);
            if (k < 5) a1 = seq_a1[k+1];
            else       a1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/porta_and_struct.md
Name: porta_and_struct

Overview:
- Structural 2-input AND cell, bit-wise over a WIDTH-bit vector, with a zero-latency combinational output y.
- Adds a registered copy of the output and a small activity monitor (all-ones flag, rise pulse, saturating high-cycle counter).
- Leaf primitive for gate-level datapaths and truth-table benches; with default WIDTH=1 it is a plain AND gate.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 8, width of the high-cycle counter.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational a AND b, bit-wise.
- y_q  output  WIDTH  y registered on clk.
- all_high  output  1  combinational reduction-AND of y (1 when every bit of y is 1).
- rise  output  1  one-cycle registered pulse on an all_high 0->1 transition.
- high_cnt  output  CNT_W  count of clock cycles where all_high was 1, saturating.

Behaviour:
- y[i] = a[i] & b[i] for every i.
  - Built structurally: one 2-input AND primitive instance per bit, via a generate loop. No behavioural "&" on the vector.
  - Purely combinational: zero latency, independent of clk and rst.
  - y is valid during reset.
- all_high = AND of all y bits. For WIDTH=1, all_high == y.
- Async reset (rst=1, any time, including mid-operation) immediately forces y_q=0, rise=0, high_cnt=0. These hold while rst=1.
- Leaving reset: rst deasserts asynchronously. The first rising clk edge with rst=0 performs normal updates.
- Each rising clk edge with rst=0:
  - y_q <= y.
  - prev_all <= all_high (internal register, reset 0).
  - rise <= all_high & ~prev_all. Because prev_all resets to 0, if all_high=1 on the first edge after reset, rise=1.
  - high_cnt <= high_cnt + 1 if all_high=1 and high_cnt != all-ones. Otherwise it holds. It saturates at 2^CNT_W-1 and never wraps.
- X/Z on inputs propagate per standard gate semantics. A 0 on either input forces a 0 output bit.
- No handshake; inputs may change at any time. Registered outputs sample the values present at the clock edge.

Test Plan:
- Truth table, WIDTH=1: apply (a,b) = 00, 01, 10, 11, holding each for 10 ns -> y = 0, 0, 0, 1. y updates within the same timestep, with no clock required.
- Register path: rst pulse, then a=1, b=1 before a clk edge -> after the edge y_q=1, rise=1 for exactly one cycle, high_cnt=1. Hold 3 more cycles -> high_cnt=4 and rise stays 0.
- Async reset mid-operation: with high_cnt=4 and y_q=1, assert rst between edges -> y_q, rise and high_cnt read 0 immediately, while y stays 1. Deassert rst -> counting restarts from 0.
- Saturation: CNT_W=2, hold a=b=1 for 6 cycles -> high_cnt reads 1, 2, 3, 3, 3, 3.
- Vector width: WIDTH=4, a=4'b1100, b=4'b1010 -> y=4'b1000, all_high=0. Then a=b=4'hF -> y=4'hF and all_high=1, with a rise pulse on the next edge.
- Drop and re-rise: sequence all_high 1, 0, 1 on successive edges -> a rise pulse on both 0->1 edges, and high_cnt increments only on cycles where all_high=1.
